// File: rtl/door_motion_supervisor_if.sv
// Sensor inputs and motor/status outputs of the door motion supervisor.
// The master side drives the sensors; the slave side (the supervisor) drives the motor and status.
interface door_motion_supervisor_if;
   logic       req_open;
   logic       estop;
   logic       lim_open;
   logic       lim_closed;
   logic       obstruct;
   logic       fault_clr;
   logic       mot_open;
   logic       mot_close;
   logic [2:0] state;
   logic       fault;

   modport master (
      output req_open, estop, lim_open, lim_closed, obstruct, fault_clr,
      input  mot_open, mot_close, state, fault
   );

   modport slave (
      input  req_open, estop, lim_open, lim_closed, obstruct, fault_clr,
      output mot_open, mot_close, state, fault
   );
endinterface

// File: rtl/door_motion_supervisor.sv
// Door sequencing FSM: converts requests, limits, obstruction and e-stop into exclusive
// open/close motor commands with dead time, auto-close hold, travel timeout and retry limit.
module door_motion_supervisor #(
   parameter int HOLD_CYCLES = 8,
   parameter int TRAVEL_MAX  = 16,
   parameter int DEADTIME    = 2,
   parameter int MAX_RETRY   = 3,
   parameter int CNT_W       = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ena,
   door_motion_supervisor_if.slave dif
);
   localparam int RETRY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

   localparam logic [CNT_W-1:0]   DEAD_LAST   = CNT_W'(DEADTIME - 1);
   localparam logic [CNT_W-1:0]   HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TRAVEL_LAST = CNT_W'(TRAVEL_MAX - 1);
   localparam logic [RETRY_W-1:0] RETRY_LAST  = RETRY_W'(MAX_RETRY - 1);

   typedef enum logic [2:0] {
      CLOSED  = 3'd0,
      DEAD_O  = 3'd1,
      OPENING = 3'd2,
      HOLD    = 3'd3,
      DEAD_C  = 3'd4,
      CLOSING = 3'd5,
      FAULT   = 3'd6,
      ESTOP   = 3'd7
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               cnt_clr;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic               mot_open_q, mot_close_q, fault_q;
   logic               lim_conflict, wake;

   assign lim_conflict = dif.lim_open & dif.lim_closed;
   assign wake         = dif.req_open | dif.obstruct;

   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      cnt_clr = 1'b0;
      if (dif.estop) begin
         state_d = ESTOP;
      end else begin
         case (state_q)
            CLOSED: begin
               if (dif.req_open) state_d = dif.lim_open ? HOLD : DEAD_O;
            end
            DEAD_O: begin
               if (cnt_q == DEAD_LAST) state_d = OPENING;
            end
            OPENING: begin
               // Reaching the limit on the last allowed cycle still counts as success.
               if (lim_conflict)               state_d = FAULT;
               else if (dif.lim_open)          state_d = HOLD;
               else if (cnt_q == TRAVEL_LAST)  state_d = FAULT;
            end
            HOLD: begin
               if (wake)                       cnt_clr = 1'b1;
               else if (cnt_q == HOLD_LAST)    state_d = DEAD_C;
            end
            DEAD_C: begin
               if (wake)                       state_d = HOLD;
               else if (cnt_q == DEAD_LAST)    state_d = CLOSING;
            end
            CLOSING: begin
               if (lim_conflict) begin
                  state_d = FAULT;
               end else if (dif.lim_closed) begin
                  state_d = CLOSED;
                  retry_d = '0;
               end else if (wake) begin
                  if (retry_q == RETRY_LAST) begin
                     state_d = FAULT;
                  end else begin
                     retry_d = retry_q + 1'b1;
                     state_d = DEAD_O;
                  end
               end else if (cnt_q == TRAVEL_LAST) begin
                  state_d = FAULT;
               end
            end
            FAULT: begin
               if (dif.fault_clr) begin
                  state_d = dif.lim_closed ? CLOSED : HOLD;
                  retry_d = '0;
               end
            end
            ESTOP: begin
               state_d = dif.lim_closed ? CLOSED : HOLD;
               retry_d = '0;
            end
            default: state_d = FAULT;
         endcase
      end

      // Saturate so a long idle period can never wrap back into a terminal count.
      if (cnt_clr || (state_d != state_q)) cnt_d = '0;
      else if (cnt_q != '1)                cnt_d = cnt_q + 1'b1;
      else                                 cnt_d = cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= CLOSED;
         cnt_q       <= '0;
         retry_q     <= '0;
         mot_open_q  <= 1'b0;
         mot_close_q <= 1'b0;
         fault_q     <= 1'b0;
      end else if (ena) begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         mot_open_q  <= (state_d == OPENING);
         mot_close_q <= (state_d == CLOSING);
         fault_q     <= (state_d == FAULT);
      end
   end

   assign dif.state     = state_q;
   assign dif.mot_open  = mot_open_q;
   assign dif.mot_close = mot_close_q;
   assign dif.fault     = fault_q;
endmodule

// File: tb/tb_door_motion_supervisor.sv
// Directed scoreboard bench for door_motion_supervisor: stimulus queues expected
// state/motor/fault per clock, a monitor pops and compares, plus motor exclusivity checks.
module tb_door_motion_supervisor;
   logic clk = 1'b0;
   logic rst_n;
   logic ena;

   door_motion_supervisor_if dif();

   door_motion_supervisor #(
      .HOLD_CYCLES(8), .TRAVEL_MAX(16), .DEADTIME(2), .MAX_RETRY(3), .CNT_W(8)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .ena  (ena),
      .dif  (dif)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] v;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   event chk_ev;

   // Expected {state, mot_open, mot_close, fault} for a given state code.
   function automatic logic [5:0] mk(input int s);
      logic [2:0] s3;
      s3 = s[2:0];
      return {s3, (s == 2), (s == 5), (s == 6)};
   endfunction

   task automatic cyc(input int s, input string nm);
      exp_t e;
      e.v = mk(s);
      e.name = nm;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic run(input int s, input int n, input string nm);
      for (int i = 0; i < n; i++) cyc(s, nm);
   endtask

   task automatic now_chk(input int s, input string nm);
      exp_t e;
      e.v = mk(s);
      e.name = nm;
      exp_q.push_back(e);
      ->chk_ev;
      #2;
   endtask

   // Monitor: compares queued expectations and checks motor direction changes.
   initial begin : monitor
      exp_t       e;
      logic [5:0] got;
      int         last_dir;
      int         gap;
      int         dir;
      last_dir = 0;
      gap = 0;
      forever begin
         @(posedge clk or chk_ev);
         #1;
         got = {dif.state, dif.mot_open, dif.mot_close, dif.fault};
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (got !== e.v) begin
               n_err++;
               $display("FAIL %s: got state=%0d mo=%b mc=%b flt=%b, expected state=%0d mo=%b mc=%b flt=%b",
                        e.name, got[5:3], got[2], got[1], got[0], e.v[5:3], e.v[2], e.v[1], e.v[0]);
            end
         end
         if (dif.mot_open && dif.mot_close) begin
            n_vec++;
            n_err++;
            $display("FAIL motor_excl: got mot_open=1 mot_close=1, expected never both");
         end
         if (dif.mot_open || dif.mot_close) begin
            dir = dif.mot_open ? 1 : 2;
            if (last_dir != 0 && dir != last_dir) begin
               n_vec++;
               if (gap < 2) begin
                  n_err++;
                  $display("FAIL dead_gap: got %0d idle cycles between directions, expected >= 2", gap);
               end
            end
            last_dir = dir;
            gap = 0;
         end else begin
            gap++;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no end of stimulus, expected completion within 200000 time units");
      $fatal(1, "bench timeout");
   end

   initial begin : stimulus
      rst_n = 1'b0;
      ena = 1'b1;
      dif.req_open = 1'b0;
      dif.estop = 1'b0;
      dif.lim_open = 1'b0;
      dif.lim_closed = 1'b1;
      dif.obstruct = 1'b0;
      dif.fault_clr = 1'b0;
      @(negedge clk);
      run(0, 2, "reset");
      rst_n = 1'b1;
      cyc(0, "idle_closed");

      // T1: full open cycle
      dif.req_open = 1'b1;   cyc(1, "t1_dead_o");
      dif.req_open = 1'b0;   dif.lim_closed = 1'b0;
      cyc(1, "t1_dead_o");
      run(2, 5, "t1_opening");
      dif.lim_open = 1'b1;   run(3, 8, "t1_hold");
      run(4, 2, "t1_dead_c");
      dif.lim_open = 1'b0;   run(5, 2, "t1_closing");
      dif.lim_closed = 1'b1; cyc(0, "t1_closed");

      // T2: travel timeout, then clear into HOLD
      dif.req_open = 1'b1;   cyc(1, "t2_dead_o");
      dif.req_open = 1'b0;   dif.lim_closed = 1'b0;
      cyc(1, "t2_dead_o");
      run(2, 16, "t2_opening");
      cyc(6, "t2_timeout");
      cyc(6, "t2_fault_hold");
      dif.fault_clr = 1'b1;  cyc(3, "t2_clr_hold");
      dif.fault_clr = 1'b0;  run(3, 7, "t2_hold");
      run(4, 2, "t2_dead_c");
      cyc(5, "t2_closing");
      dif.lim_closed = 1'b1; cyc(0, "t2_closed");

      // T3: obstruction reversals up to the retry limit
      dif.req_open = 1'b1;   cyc(1, "t3_dead_o");
      dif.req_open = 1'b0;   dif.lim_closed = 1'b0;
      cyc(1, "t3_dead_o");
      cyc(2, "t3_opening");
      dif.lim_open = 1'b1;   run(3, 8, "t3_hold");
      run(4, 2, "t3_dead_c");
      dif.lim_open = 1'b0;   cyc(5, "t3_closing");
      for (int r = 0; r < 2; r++) begin
         dif.obstruct = 1'b1; cyc(1, "t3_reverse");
         dif.obstruct = 1'b0; cyc(1, "t3_dead_o");
         cyc(2, "t3_reopen");
         dif.lim_open = 1'b1; run(3, 8, "t3_hold");
         run(4, 2, "t3_dead_c");
         dif.lim_open = 1'b0; cyc(5, "t3_closing");
      end
      dif.obstruct = 1'b1;   cyc(6, "t3_retry_fault");
      dif.obstruct = 1'b0;   cyc(6, "t3_fault_hold");
      dif.lim_closed = 1'b1; dif.fault_clr = 1'b1;
      cyc(0, "t3_clr_closed");
      dif.fault_clr = 1'b0;

      // T4: e-stop during OPENING
      dif.req_open = 1'b1;   cyc(1, "t4_dead_o");
      dif.req_open = 1'b0;   dif.lim_closed = 1'b0;
      cyc(1, "t4_dead_o");
      run(2, 2, "t4_opening");
      dif.estop = 1'b1;      run(7, 2, "t4_estop");
      dif.estop = 1'b0;      dif.lim_closed = 1'b1;
      cyc(0, "t4_release");

      // T5: hold extension, DEAD_C abort, limit conflict
      dif.lim_open = 1'b1;   dif.lim_closed = 1'b0; dif.req_open = 1'b1;
      cyc(3, "t5_direct_hold");
      dif.req_open = 1'b0;
      for (int p = 0; p < 3; p++) begin
         run(3, 4, "t5_hold");
         dif.req_open = 1'b1; cyc(3, "t5_extend");
         dif.req_open = 1'b0;
      end
      run(3, 7, "t5_hold_tail");
      cyc(4, "t5_dead_c");
      dif.obstruct = 1'b1;   cyc(3, "t5_dc_abort");
      dif.obstruct = 1'b0;   run(3, 7, "t5_hold");
      run(4, 2, "t5_dead_c");
      dif.lim_open = 1'b0;   cyc(5, "t5_closing");
      dif.lim_open = 1'b1;   dif.lim_closed = 1'b1;
      cyc(6, "t5_lim_conflict");
      dif.fault_clr = 1'b1;  cyc(0, "t5_clr_closed");
      dif.fault_clr = 1'b0;  cyc(0, "t5_conflict_ignored");
      dif.lim_open = 1'b0;

      // T6: clock-enable freeze in DEAD_O, then async reset while closing
      dif.req_open = 1'b1;   cyc(1, "t6_dead_o");
      dif.req_open = 1'b0;   dif.lim_closed = 1'b0; ena = 1'b0;
      run(1, 10, "t6_frozen");
      ena = 1'b1;            cyc(1, "t6_resume");
      cyc(2, "t6_opening");
      dif.lim_open = 1'b1;   run(3, 8, "t6_hold");
      run(4, 2, "t6_dead_c");
      dif.lim_open = 1'b0;   run(5, 2, "t6_closing");
      #2;
      rst_n = 1'b0;
      now_chk(0, "t6_async_rst");
      cyc(0, "t6_in_reset");
      rst_n = 1'b1;          dif.lim_closed = 1'b1;
      cyc(0, "t6_after_rst");

      @(posedge clk);
      #3;
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
